// File: rtl/billiard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : billiard_pkg
//  Description : Shared table geometry, fixed-point format, motion limits and
//                the ball motion state encoding, plus the velocity clip helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package billiard_pkg;

    localparam int c_initial_x    = 320;
    localparam int c_initial_y    = 240;
    localparam int c_ball_size    = 16;
    localparam int c_table_left   = 32;
    localparam int c_table_right  = 607;
    localparam int c_table_top    = 32;
    localparam int c_table_bottom = 447;
    localparam int c_frac_bits    = 6;
    localparam int c_friction     = 1;
    localparam int c_max_velocity = 510;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        STOP = 2'd2
    } motion_state_t;

    // Saturate a shot velocity to +/-max_mag.
    function automatic logic signed [31:0] clip_velocity(
        input logic signed [31:0] v,
        input int                 max_mag
    );
        if (v > max_mag) begin
            return max_mag;
        end else if (v < -max_mag) begin
            return -max_mag;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : axis_integrator
//  Description : One axis of ball motion. Holds the fixed-point position
//                {11-bit pixel, FRAC_BITS fraction} and the signed velocity.
//                On i_load the velocity is latched (clipped). On i_step the
//                position integrates, reflects off the cushions and friction
//                is applied to the velocity.
//  Ports       : clk, rst            - clock, async active-high reset
//                i_load, i_vel       - latch clipped shot velocity
//                i_step              - apply one frame update
//                o_pixel             - integer pixel of position
//                o_hit               - this step reflects off a cushion
//                o_next_vel_zero     - velocity after this step is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_integrator
    import billiard_pkg::*;
#(
    parameter int INIT_PIX     = 320,
    parameter int LOW_PIX      = 32,
    parameter int HIGH_PIX     = 592,
    parameter int FRAC_BITS    = 6,
    parameter int FRICTION     = 1,
    parameter int MAX_VELOCITY = 510
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic signed [31:0] i_vel,
    input  logic               i_step,
    output logic [10:0]        o_pixel,
    output logic               o_hit,
    output logic               o_next_vel_zero
);

    localparam int c_pos_w = 11 + FRAC_BITS;
    localparam int c_low_fx  = LOW_PIX * (2 ** FRAC_BITS);
    localparam int c_high_fx = HIGH_PIX * (2 ** FRAC_BITS);
    localparam logic [c_pos_w-1:0] c_init_pos = c_pos_w'(INIT_PIX * (2 ** FRAC_BITS));
    localparam logic [c_pos_w-1:0] c_low_pos  = c_pos_w'(c_low_fx);
    localparam logic [c_pos_w-1:0] c_high_pos = c_pos_w'(c_high_fx);

    logic [c_pos_w-1:0] r_pos;
    logic signed [31:0] r_vel;

    logic signed [31:0] w_sum;
    logic [c_pos_w-1:0] w_pos_next;
    logic signed [31:0] w_vel_refl;
    logic signed [31:0] w_vel_next;
    logic               w_hit;

    // Signed 32-bit sum: a negative result compares below the low bound
    // instead of wrapping to a large unsigned position.
    assign w_sum = $signed({{(32-c_pos_w){1'b0}}, r_pos}) + r_vel;

    always_comb begin
        w_pos_next = w_sum[c_pos_w-1:0];
        w_vel_refl = r_vel;
        w_hit      = 1'b0;
        if (w_sum < c_low_fx) begin
            w_pos_next = c_low_pos;
            w_vel_refl = -r_vel;
            w_hit      = 1'b1;
        end else if (w_sum > c_high_fx) begin
            w_pos_next = c_high_pos;
            w_vel_refl = -r_vel;
            w_hit      = 1'b1;
        end
    end

    // Friction acts on the post-reflection velocity.
    always_comb begin
        w_vel_next = w_vel_refl - FRICTION;
        if ((w_vel_refl <= FRICTION) && (w_vel_refl >= -FRICTION)) begin
            w_vel_next = '0;
        end else if (w_vel_refl < 0) begin
            w_vel_next = w_vel_refl + FRICTION;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= c_init_pos;
            r_vel <= '0;
        end else if (i_load) begin
            r_vel <= clip_velocity(i_vel, MAX_VELOCITY);
        end else if (i_step) begin
            r_pos <= w_pos_next;
            r_vel <= w_vel_next;
        end
    end

    assign o_pixel         = r_pos[c_pos_w-1:FRAC_BITS];
    assign o_hit           = w_hit;
    assign o_next_vel_zero = (w_vel_next == 0);

endmodule
`default_nettype wire

// File: rtl/ball_shot_motion.sv
`default_nettype none
// ============================================================================
//  Module      : ball_shot_motion
//  Description : Moves the white ball one step per video frame after a shot.
//                IDLE waits for a non-zero shot, MOVE integrates both axes on
//                every startOfFrame until both velocities reach zero, STOP
//                lasts one clock before returning to IDLE.
//  Ports       : clk, reset                 - clock, async active-high reset
//                startOfFrame               - one-clk frame pulse
//                shoot, velocityX/Y         - shot launch and velocity
//                whiteBallTopLeftX/Y        - ball top-left pixel
//                no_moving_flag             - ball at rest
//                wall_hit                   - one-clk cushion reflection pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_shot_motion
    import billiard_pkg::*;
#(
    parameter int INITIAL_X    = c_initial_x,
    parameter int INITIAL_Y    = c_initial_y,
    parameter int BALL_SIZE    = c_ball_size,
    parameter int TABLE_LEFT   = c_table_left,
    parameter int TABLE_RIGHT  = c_table_right,
    parameter int TABLE_TOP    = c_table_top,
    parameter int TABLE_BOTTOM = c_table_bottom,
    parameter int FRAC_BITS    = c_frac_bits,
    parameter int FRICTION     = c_friction,
    parameter int MAX_VELOCITY = c_max_velocity
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               shoot,
    input  logic signed [31:0] velocityX,
    input  logic signed [31:0] velocityY,
    output logic [10:0]        whiteBallTopLeftX,
    output logic [10:0]        whiteBallTopLeftY,
    output logic               no_moving_flag,
    output logic               wall_hit
);

    motion_state_t r_state;
    logic          r_no_moving;
    logic          r_wall_hit;

    logic w_load;
    logic w_step;
    logic w_hit_x;
    logic w_hit_y;
    logic w_zero_x;
    logic w_zero_y;

    // A shoot arriving outside IDLE is simply not loaded.
    assign w_load = (r_state == IDLE) && shoot;
    assign w_step = (r_state == MOVE) && startOfFrame;

    axis_integrator #(
        .INIT_PIX     (INITIAL_X),
        .LOW_PIX      (TABLE_LEFT),
        .HIGH_PIX     (TABLE_RIGHT - BALL_SIZE + 1),
        .FRAC_BITS    (FRAC_BITS),
        .FRICTION     (FRICTION),
        .MAX_VELOCITY (MAX_VELOCITY)
    ) u_axis_x (
        .clk             (clk),
        .rst             (reset),
        .i_load          (w_load),
        .i_vel           (velocityX),
        .i_step          (w_step),
        .o_pixel         (whiteBallTopLeftX),
        .o_hit           (w_hit_x),
        .o_next_vel_zero (w_zero_x)
    );

    axis_integrator #(
        .INIT_PIX     (INITIAL_Y),
        .LOW_PIX      (TABLE_TOP),
        .HIGH_PIX     (TABLE_BOTTOM - BALL_SIZE + 1),
        .FRAC_BITS    (FRAC_BITS),
        .FRICTION     (FRICTION),
        .MAX_VELOCITY (MAX_VELOCITY)
    ) u_axis_y (
        .clk             (clk),
        .rst             (reset),
        .i_load          (w_load),
        .i_vel           (velocityY),
        .i_step          (w_step),
        .o_pixel         (whiteBallTopLeftY),
        .o_hit           (w_hit_y),
        .o_next_vel_zero (w_zero_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_no_moving <= 1'b1;
            r_wall_hit  <= 1'b0;
        end else begin
            r_wall_hit <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Clipping never maps a non-zero value to zero, so the
                    // raw inputs decide whether the shot is ignored.
                    if (shoot && ((velocityX != 0) || (velocityY != 0))) begin
                        r_state     <= MOVE;
                        r_no_moving <= 1'b0;
                    end
                end
                MOVE: begin
                    if (startOfFrame) begin
                        r_wall_hit <= w_hit_x || w_hit_y;
                        if (w_zero_x && w_zero_y) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    r_state     <= IDLE;
                    r_no_moving <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_no_moving <= 1'b1;
                end
            endcase
        end
    end

    assign no_moving_flag = r_no_moving;
    assign wall_hit       = r_wall_hit;

endmodule
`default_nettype wire

// File: tb/tb_ball_shot_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_shot_motion
//  Description : Self-checking bench for ball_shot_motion. A frame-level
//                reference model (integer fixed-point position and velocity
//                per axis) predicts position, wall_hit and no_moving_flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_shot_motion;

    localparam int c_lo_x = 32;
    localparam int c_hi_x = 607 - 16 + 1;
    localparam int c_lo_y = 32;
    localparam int c_hi_y = 447 - 16 + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               shoot = 1'b0;
    logic signed [31:0] velocityX = '0;
    logic signed [31:0] velocityY = '0;
    logic [10:0]        whiteBallTopLeftX;
    logic [10:0]        whiteBallTopLeftY;
    logic               no_moving_flag;
    logic               wall_hit;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state (positions in 1/64 pixel).
    int mx, my, mvx, mvy;
    bit m_moving;
    bit m_last_hit;
    int n_hit_seen;

    ball_shot_motion dut (
        .clk               (clk),
        .reset             (reset),
        .startOfFrame      (startOfFrame),
        .shoot             (shoot),
        .velocityX         (velocityX),
        .velocityY         (velocityY),
        .whiteBallTopLeftX (whiteBallTopLeftX),
        .whiteBallTopLeftY (whiteBallTopLeftY),
        .no_moving_flag    (no_moving_flag),
        .wall_hit          (wall_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clip(input int v);
        if (v > 510) return 510;
        if (v < -510) return -510;
        return v;
    endfunction

    task automatic step_axis(inout int p, inout int v, input int lo, input int hi, output bit hit);
        p   = p + v;
        hit = 1'b0;
        if (p < lo * 64) begin
            p = lo * 64; v = -v; hit = 1'b1;
        end else if (p > hi * 64) begin
            p = hi * 64; v = -v; hit = 1'b1;
        end
        if (v >= -1 && v <= 1) v = 0;
        else if (v > 0)        v = v - 1;
        else                   v = v + 1;
    endtask

    task automatic model_reset();
        mx = 320 * 64; my = 240 * 64; mvx = 0; mvy = 0;
        m_moving = 1'b0; m_last_hit = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must respond without a clock edge.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_x", whiteBallTopLeftX, 320);
        check("rst_y", whiteBallTopLeftY, 240);
        check("rst_flag", no_moving_flag, 1);
        check("rst_hit", wall_hit, 0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_hold_flag", no_moving_flag, 1);
    endtask

    task automatic do_shoot(input int vx, input int vy, input bit sof);
        int px, py;
        px = mx; py = my;
        velocityX    = vx;
        velocityY    = vy;
        shoot        = 1'b1;
        startOfFrame = sof && !m_moving;
        tick();
        shoot        = 1'b0;
        startOfFrame = 1'b0;
        if (!m_moving && (clip(vx) != 0 || clip(vy) != 0)) begin
            mvx = clip(vx); mvy = clip(vy); m_moving = 1'b1;
        end
        check("shot_flag", no_moving_flag, m_moving ? 0 : 1);
        check("shot_x", whiteBallTopLeftX, px / 64);
        check("shot_y", whiteBallTopLeftY, py / 64);
        check("shot_hit", wall_hit, 0);
    endtask

    task automatic do_frame(input int gap, input bit shoot_in_stop);
        bit hx, hy;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        m_last_hit = 1'b0;
        if (m_moving) begin
            step_axis(mx, mvx, c_lo_x, c_hi_x, hx);
            step_axis(my, mvy, c_lo_y, c_hi_y, hy);
            m_last_hit = hx | hy;
        end
        check("frame_x", whiteBallTopLeftX, mx / 64);
        check("frame_y", whiteBallTopLeftY, my / 64);
        check("frame_hit", wall_hit, m_last_hit);
        if (wall_hit === 1'b1) n_hit_seen++;
        if (m_moving && mvx == 0 && mvy == 0) begin
            m_moving = 1'b0;
            check("stop_flag", no_moving_flag, 0);
            if (shoot_in_stop) begin
                velocityX = 300;
                velocityY = -300;
                shoot     = 1'b1;
            end
            tick();
            shoot = 1'b0;
            check("idle_flag", no_moving_flag, 1);
            check("stop_hit_clear", wall_hit, 0);
        end else begin
            check("frame_flag", no_moving_flag, m_moving ? 0 : 1);
        end
        for (int i = 0; i < gap; i++) begin
            tick();
            check("gap_hit", wall_hit, 0);
            check("gap_flag", no_moving_flag, m_moving ? 0 : 1);
        end
    endtask

    task automatic run_to_rest(input int max_frames, input bit rnd);
        for (int f = 0; f < max_frames && m_moving; f++) begin
            do_frame(rnd ? int'($urandom_range(1, 3)) : 1, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        if (m_moving) check("rest_timeout", 0, 1);
    endtask

    initial begin
        model_reset();
        n_hit_seen = 0;

        // Power-on reset, asserted between edges.
        #1;
        reset = 1'b1;
        #1;
        check("init_x", whiteBallTopLeftX, 320);
        check("init_y", whiteBallTopLeftY, 240);
        check("init_flag", no_moving_flag, 1);
        check("init_hit", wall_hit, 0);
        tick();
        reset = 1'b0;
        tick();

        // Straight shot.
        do_shoot(64, 0, 1'b0);
        run_to_rest(100, 1'b0);
        check("straight_x", whiteBallTopLeftX, 352);
        check("straight_y", whiteBallTopLeftY, 240);

        // Reset mid-motion.
        do_shoot(300, -200, 1'b0);
        repeat (5) do_frame(1, 1'b0);
        do_reset();

        // Clip and left wall.
        do_shoot(-1000, 0, 1'b0);
        n_hit_seen = 0;
        do_frame(1, 1'b0);
        check("clip_first_x", whiteBallTopLeftX, 312);
        for (int f = 0; f < 100 && !m_last_hit; f++) do_frame(1, 1'b0);
        check("clip_wall_x", whiteBallTopLeftX, 32);
        check("clip_one_pulse", n_hit_seen, 1);
        do_frame(1, 1'b0);
        check("clip_rebound", (whiteBallTopLeftX > 11'd32) ? 1 : 0, 1);
        run_to_rest(600, 1'b0);

        // Corner: park at (33,33), then shoot diagonally into the corner.
        do_reset();
        do_shoot(-191, 0, 1'b0);
        run_to_rest(300, 1'b0);
        do_shoot(0, -162, 1'b0);
        run_to_rest(300, 1'b0);
        check("corner_pre_x", whiteBallTopLeftX, 33);
        check("corner_pre_y", whiteBallTopLeftY, 33);
        do_shoot(-128, -128, 1'b0);
        n_hit_seen = 0;
        do_frame(1, 1'b0);
        check("corner_x", whiteBallTopLeftX, 32);
        check("corner_y", whiteBallTopLeftY, 32);
        check("corner_pulse", n_hit_seen, 1);
        do_frame(1, 1'b0);
        check("corner_out_x", whiteBallTopLeftX, 33);
        check("corner_out_y", whiteBallTopLeftY, 33);
        run_to_rest(300, 1'b0);

        // Zero shot is ignored.
        do_shoot(0, 0, 1'b0);
        do_frame(2, 1'b0);

        // Second shoot during motion is ignored.
        do_shoot(200, 150, 1'b0);
        repeat (10) do_frame(1, 1'b0);
        do_shoot(-400, 300, 1'b0);
        run_to_rest(600, 1'b0);

        // Shoot coincident with startOfFrame: no move that frame.
        do_shoot(100, -90, 1'b1);
        run_to_rest(200, 1'b0);

        // Randomized shots.
        for (int s = 0; s < 12; s++) begin
            int vx, vy, extra_at;
            vx = int'($urandom_range(0, 1400)) - 700;
            vy = int'($urandom_range(0, 1400)) - 700;
            if ($urandom_range(0, 5) == 0) vx = 0;
            if ($urandom_range(0, 5) == 0) vy = 0;
            do_shoot(vx, vy, 1'($urandom_range(0, 1)));
            extra_at = int'($urandom_range(0, 20));
            for (int f = 0; f < extra_at && m_moving; f++) do_frame(int'($urandom_range(1, 3)), 1'b0);
            do_shoot(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500, 1'b0);
            run_to_rest(600, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ball_shot_motion.md
Name: ball_shot_motion

Overview:
Consumes the shot velocity pair from the cue-stick block and moves the white ball across the table, one step per video frame. Each frame it integrates position in fixed point, applies rolling friction, and reflects the ball off the cushions. When the ball comes to rest it asserts no_moving_flag, which re-enables aiming in the cue-stick block. It sits between the stick logic and the ball drawing/collision logic.

Parameters:
INITIAL_X, 320, reset top-left X of ball (pixels)
INITIAL_Y, 240, reset top-left Y of ball (pixels)
BALL_SIZE, 16, ball width/height (pixels)
TABLE_LEFT, 32, leftmost legal top-left X
TABLE_RIGHT, 607, rightmost pixel of playfield; max top-left X = TABLE_RIGHT-BALL_SIZE+1
TABLE_TOP, 32, topmost legal top-left Y
TABLE_BOTTOM, 447, bottom pixel of playfield; max top-left Y = TABLE_BOTTOM-BALL_SIZE+1
FRAC_BITS, 6, fractional bits of position; velocity unit = 1/64 pixel/frame
FRICTION, 1, velocity magnitude removed per frame per axis
MAX_VELOCITY, 510, per-axis velocity clip magnitude

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-clk pulse per video frame
shoot  in  1  one-clk pulse: launch ball with current velocityX/velocityY
velocityX  in  32 signed  shot X velocity, positive = increasing X
velocityY  in  32 signed  shot Y velocity, positive = increasing Y
whiteBallTopLeftX  out  11  ball top-left X (integer pixel)
whiteBallTopLeftY  out  11  ball top-left Y (integer pixel)
no_moving_flag  out  1  1 = ball at rest, aiming allowed
wall_hit  out  1  one-clk pulse on any cushion reflection

Behaviour:
- Reset (asynchronous, active-high): position = (INITIAL_X, INITIAL_Y) with fraction 0; velocities 0; state IDLE; no_moving_flag=1; wall_hit=0.
- Internal position per axis: unsigned {11-bit pixel, FRAC_BITS fraction}. Outputs are the pixel field, registered.
- FSM states:
  - IDLE: no_moving_flag=1. On shoot, latch both velocities, each clipped to ±MAX_VELOCITY, and go to MOVE. If both clipped values are 0, the shot is ignored and the FSM stays in IDLE.
  - MOVE: no_moving_flag=0. On each startOfFrame, per axis and in this order:
    1. pos += v.
    2. Wall check. If the result is below the low bound, clamp to the bound (fraction 0) and set v = -v. Same for above the high bound.
    3. Friction. If |v| <= FRICTION then v = 0, else v moves toward 0 by FRICTION.
    When both velocities are 0 after the update, go to STOP.
  - STOP: one clk, then IDLE. no_moving_flag rises on the IDLE entry clk.
- Latency: shoot to no_moving_flag low = 1 clk. The first position change happens on the first startOfFrame strictly after the shoot clk.
- wall_hit pulses for 1 clk on the startOfFrame update that reflected either axis. It is a single pulse even if both axes reflect.
- Boundary conditions:
  - shoot in MOVE or STOP is ignored.
  - shoot coincident with startOfFrame in IDLE: the latch wins, no position update that frame.
  - Arithmetic uses 32-bit signed intermediates. A negative intermediate position is treated as below the low bound and never wraps.
  - Reflection at a corner flips both axes in the same frame.
  - Reset mid-motion returns to the reset state immediately.

Decomposition:
- Shared package billiard_pkg holds the table bound constants, FRAC_BITS, MAX_VELOCITY and the motion_state_t enum {IDLE, MOVE, STOP}.
- One sub-module, axis_integrator, instantiated for X and Y. It contains the fixed-point position register, velocity register, clip-on-load, integrate, reflect and friction logic, plus a per-axis hit output. The top level holds the FSM, combines the hit outputs, and generates wall_hit.

Test Plan:
- Reset: assert reset mid-frame -> outputs (320,240), no_moving_flag=1, wall_hit=0 asynchronously, without waiting for a clk edge.
- Straight shot: shoot with vx=64, vy=0 -> no_moving_flag=0 next clk; ball moves 64 frames; final X = 320 + floor(2080/64) = 352, Y=240; no_moving_flag=1 two clks after the 64th startOfFrame.
- Clip and wall: shoot with vx=-1000, vy=0 -> latched vx=-510; X reaches clamp 32; wall_hit pulses exactly once; vx becomes positive and X then increases.
- Corner: ball at (33,33), shoot vx=-128, vy=-128 -> both axes clamp to 32 in the same frame, single wall_hit pulse, both velocities positive.
- Ignored events: shoot with (0,0) -> no_moving_flag stays 1. Second shoot during MOVE -> trajectory unchanged versus a reference run.
- Simultaneous: shoot on the same clk as startOfFrame -> position unchanged that frame, first move on the next startOfFrame.
